gen_mask: RTL and testbench
===========================

GEN_MASK -- requirements
Module: gen_mask

Interface
REQ-001 The block SHALL have parameter SEQ_WIDTH, default 20, giving the sequence length in bits; the legal range SHALL be 1..127.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_offset, input, 7 bits: unsigned correlation offset k, 0..127.
REQ-005 The block SHALL have port o_mask, output, SEQ_WIDTH bits: registered valid-pair mask for offset k.

Function
REQ-006 Each clock cycle, the block SHALL sample i_offset with no handshake; there SHALL be no valid or enable signal.
REQ-007 For each bit position i (0..SEQ_WIDTH-1), the next o_mask[i] SHALL be 1 when i < SEQ_WIDTH - k, and 0 otherwise.
- This marks the positions i where the pair (s[i], s[i+k]) lies inside the sequence.
REQ-008 o_mask SHALL be registered, with a latency of exactly 1 clock.
- The value presented on i_offset before rising edge n SHALL appear on o_mask after edge n.
REQ-009 When k = 0, the next o_mask SHALL be all ones.
REQ-010 When k >= SEQ_WIDTH, the next o_mask SHALL be all zeros.
- This includes every value up to 127; no wrap-around or modulo behaviour is permitted.
REQ-011 The comparison SHALL be performed unsigned, at a width of at least max(7, clog2(SEQ_WIDTH+1)) bits, so that SEQ_WIDTH - k never underflows.
REQ-012 The set bits of o_mask SHALL always form a contiguous run starting at bit 0 (a thermometer code).
- The population count SHALL equal max(SEQ_WIDTH - k, 0).
REQ-013 If i_offset changes every cycle, o_mask SHALL track it every cycle with no holes or stalls.
REQ-014 The block SHALL be purely combinational from i_offset to the register input.
- It SHALL contain no state other than the o_mask register.

Reset
REQ-015 While rst = 1, o_mask SHALL be all zeros, asynchronously and independent of clk.
REQ-016 On the first rising edge after rst deasserts, o_mask SHALL take the value of the REQ-007 mapping for the i_offset value present at that edge.
REQ-017 If reset asserts mid-stream, o_mask SHALL clear immediately.
- The output SHALL carry no memory of pre-reset offsets.
REQ-018 The o_mask value before the first reset SHALL be undefined; the verification bench SHALL NOT check it.

Structure
REQ-019 A shared package labs_pkg SHALL hold:
- OFFSET_WIDTH = 7;
- the default SEQ_WIDTH = 20;
- a SEQ_WIDTH-bit mask typedef for reuse by the correlation datapath.
REQ-020 gen_mask SHALL be a single module with no sub-modules.
- A generate loop SHALL produce one comparator per bit, feeding one register vector.
REQ-021 An elaboration-time check SHALL reject SEQ_WIDTH < 1 or SEQ_WIDTH > 127.

Verification
REQ-022 Scenario, reset: rst high for 4 cycles with i_offset = 0 -> o_mask = 0x00000 throughout; one cycle after rst falls -> o_mask = 0xFFFFF.
REQ-023 Scenario, sweep: i_offset = 0..127, one value per cycle -> one cycle later o_mask equals:
- k=0: 0xFFFFF;
- k=1: 0x7FFFF;
- k=10: 0x003FF;
- k=19: 0x00001;
- k=20..127: 0x00000.
REQ-024 Scenario, popcount: for every k in 0..127, popcount(o_mask) = max(20 - k, 0), and o_mask + 1 is a power of two.
REQ-025 Scenario, latency: step i_offset from 0 to 5 -> o_mask stays 0xFFFFF until the next rising edge, then becomes 0x07FFF.
REQ-026 Scenario, mid-stream reset: pulse rst between clock edges while i_offset = 3 -> o_mask goes to 0x00000 immediately; first edge after release -> 0x1FFFF.
REQ-027 Scenario, alternate widths: re-run the sweep with SEQ_WIDTH = 1 and SEQ_WIDTH = 64 -> popcount rule holds; k = SEQ_WIDTH gives all zeros.

Source files
------------

// File: rtl/labs_pkg.sv
// Shared definitions for the correlation blocks: offset width,
// default sequence length and a mask type for the datapath.
package labs_pkg;

    localparam int OFFSET_WIDTH  = 7;
    localparam int SEQ_WIDTH_DEF = 20;

    // Mask of valid (s[i], s[i+k]) pairs at the default sequence length
    typedef logic [SEQ_WIDTH_DEF-1:0] mask_t;

endpackage

// File: rtl/gen_mask_if.sv
// Offset-in / mask-out bundle between an offset source and gen_mask.
interface gen_mask_if
    import labs_pkg::*;
#(
    parameter int SEQ_WIDTH = SEQ_WIDTH_DEF
);
    logic [OFFSET_WIDTH-1:0] i_offset;
    logic [SEQ_WIDTH-1:0]    o_mask;

    // Offset source: drives the offset and consumes the mask
    modport master (output i_offset, input o_mask);
    // Mask generator side
    modport slave  (input i_offset, output o_mask);
endinterface

// File: rtl/gen_mask.sv
// Valid-pair mask generator: bit i of the registered mask is set when
// the pair (s[i], s[i+k]) fits inside a SEQ_WIDTH-bit sequence.
// Output is a thermometer code of length max(SEQ_WIDTH - k, 0).
module gen_mask
    import labs_pkg::*;
#(
    parameter int SEQ_WIDTH = SEQ_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    output logic [SEQ_WIDTH-1:0]    o_mask
);

    // i + k tops out at 126 + 127 = 253, so 8 bits hold the sum without
    // wrapping; comparing i + k < SEQ_WIDTH avoids any subtraction.
    localparam int CMP_W = 8;

    if (SEQ_WIDTH < 1 || SEQ_WIDTH > 127) begin : g_bad_width
        $error("gen_mask: SEQ_WIDTH %0d outside 1..127", SEQ_WIDTH);
    end

    logic [CMP_W-1:0]     w_offset_ext;
    logic [SEQ_WIDTH-1:0] w_mask_next;
    logic [SEQ_WIDTH-1:0] r_mask;

    assign w_offset_ext = CMP_W'(i_offset);

    // One comparator per mask bit
    for (genvar gi = 0; gi < SEQ_WIDTH; gi++) begin : g_cmp
        assign w_mask_next[gi] = (w_offset_ext + CMP_W'(gi)) < CMP_W'(SEQ_WIDTH);
    end

    // Mask register, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else begin
            r_mask <= w_mask_next;
        end
    end

    assign o_mask = r_mask;

endmodule

// File: tb/tb_gen_mask.sv
// Bench for gen_mask at SEQ_WIDTH = 20, 1 and 64 sharing one offset.
module tb_gen_mask;
    import labs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [OFFSET_WIDTH-1:0] off;

    always #5 clk = ~clk;

    gen_mask_if #(.SEQ_WIDTH(20)) if20 ();
    gen_mask_if #(.SEQ_WIDTH(1))  if1  ();
    gen_mask_if #(.SEQ_WIDTH(64)) if64 ();

    assign if20.i_offset = off;
    assign if1.i_offset  = off;
    assign if64.i_offset = off;

    gen_mask #(.SEQ_WIDTH(20)) u_dut20 (.clk(clk), .rst(rst), .i_offset(if20.i_offset), .o_mask(if20.o_mask));
    gen_mask #(.SEQ_WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .i_offset(if1.i_offset),  .o_mask(if1.o_mask));
    gen_mask #(.SEQ_WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .i_offset(if64.i_offset), .o_mask(if64.o_mask));

    int n_cmp = 0;
    int n_err = 0;
    int q_k[$];

    // Reference thermometer: low (w - k) bits set, none when k >= w
    function automatic logic [63:0] model(input int w, input int k);
        if (k >= w) return 64'd0;
        if (w - k == 64) return {64{1'b1}};
        return (64'd1 << (w - k)) - 64'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_width(input int w, input logic [63:0] o, input int k);
        logic [64:0] t;
        chk($sformatf("mask w%0d k%0d", w, k), o, model(w, k));
        chk($sformatf("popcount w%0d k%0d", w, k), 64'($countones(o)), 64'((w > k) ? (w - k) : 0));
        t = {1'b0, o} + 65'd1;
        chk($sformatf("pow2 w%0d k%0d", w, k), 64'((t & (t - 65'd1)) == 65'd0), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " w20"}, {44'd0, if20.o_mask}, 64'd0);
        chk({tag, " w1"},  {63'd0, if1.o_mask},  64'd0);
        chk({tag, " w64"}, if64.o_mask,          64'd0);
    endtask

    // Pop the expected offset and compare all three instances
    task automatic check_sb();
        int k;
        if (q_k.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        k = q_k.pop_front();
        check_width(20, {44'd0, if20.o_mask}, k);
        check_width(1,  {63'd0, if1.o_mask},  k);
        check_width(64, if64.o_mask,          k);
        case (k)
            0:       chk("table k0",  {44'd0, if20.o_mask}, 64'hFFFFF);
            1:       chk("table k1",  {44'd0, if20.o_mask}, 64'h7FFFF);
            10:      chk("table k10", {44'd0, if20.o_mask}, 64'h003FF);
            19:      chk("table k19", {44'd0, if20.o_mask}, 64'h00001);
            default: if (k >= 20) chk($sformatf("table k%0d", k), {44'd0, if20.o_mask}, 64'h00000);
        endcase
    endtask

    task automatic step(input int k);
        @(negedge clk);
        off = 7'(k);
        q_k.push_back(k);
        @(posedge clk);
        #1;
        check_sb();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        off = '0;

        // Reset held for 4 cycles
        repeat (4) begin
            @(negedge clk);
            check_zero("reset hold");
        end
        @(negedge clk);
        rst = 1'b0;
        q_k.push_back(0);
        @(posedge clk);
        #1;
        check_sb();

        // Full offset sweep, one value per cycle
        for (int k = 0; k < 128; k++) step(k);

        // Latency: output holds until the next edge
        step(0);
        @(negedge clk);
        off = 7'd5;
        q_k.push_back(5);
        #1;
        chk("latency hold", {44'd0, if20.o_mask}, 64'hFFFFF);
        @(posedge clk);
        #1;
        check_sb();
        chk("latency k5", {44'd0, if20.o_mask}, 64'h07FFF);

        // Mid-stream reset pulse between edges
        step(3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero("midreset asserted");
        #1 rst = 1'b0;
        #1 check_zero("midreset released");
        q_k.push_back(3);
        @(posedge clk);
        #1;
        check_sb();
        chk("midreset k3", {44'd0, if20.o_mask}, 64'h1FFFF);

        // Offset changing every cycle
        repeat (40) step(int'($urandom_range(0, 127)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
